uart_rx_oversample: RTL
=======================

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..8).
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 = one parity bit follows the data.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
REQ-004 SHALL have port clk  input  1  meaning system clock; all logic is on the rising edge.
REQ-005 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-006 SHALL have port tick  input  1  meaning 16x-baud enable pulse, one clk wide, from the baud-rate generator.
REQ-007 SHALL have port rx  input  1  meaning asynchronous serial line; idles high.
REQ-008 SHALL have port rx_data  output  DATA_BITS  meaning last received payload, LSB first on the line.
REQ-009 SHALL have port rx_valid  output  1  meaning one-clk pulse when rx_data/rx_frame_err/rx_parity_err update.
REQ-010 SHALL have port rx_frame_err  output  1  meaning stop bit of the last frame sampled low.
REQ-011 SHALL have port rx_parity_err  output  1  meaning parity mismatch on the last frame; always 0 when PARITY_EN = 0.
REQ-012 SHALL have port busy  output  1  meaning FSM not in IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s) whose flops reset to 1; all decisions use rx_s only.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK; a 4-bit tick counter (cnt) and a 3-bit bit index (idx).
REQ-015 SHALL advance cnt only on clocks where tick = 1; clocks without tick hold cnt and state except where stated.
REQ-016 IDLE: when rx_s = 0 (checked every clk, tick not required), SHALL go to START with cnt = 0.
REQ-017 START: on a tick with cnt = 7, SHALL go to DATA with cnt = 0 and idx = 0 if rx_s = 0; otherwise SHALL return to IDLE (glitch rejection, no rx_valid).
REQ-018 DATA: on a tick with cnt = 15, SHALL sample rx_s into a shift register (shift right, new bit enters at MSB of DATA_BITS), set cnt = 0, increment idx; after bit DATA_BITS-1, SHALL go to PARITY if PARITY_EN else STOP.
REQ-019 PARITY: on a tick with cnt = 15, SHALL sample rx_s; error if XOR(data bits, sampled bit) != PARITY_ODD; then go to STOP, cnt = 0.
REQ-020 STOP: on a tick with cnt = 15, SHALL load rx_data from the shift register, set rx_frame_err = ~rx_s, set rx_parity_err, and assert rx_valid on the following clk only.
REQ-021 From STOP SHALL go to IDLE if stop sample = 1, else to BREAK.
REQ-022 BREAK: SHALL stay until rx_s = 1, then go to IDLE; no start detection while in BREAK.
REQ-023 SHALL update rx_data, rx_frame_err and rx_parity_err on a frame with a stop-bit error too; they hold their values between frames.
REQ-024 Latency: rx_valid SHALL rise exactly 1 clk after the tick that samples the stop bit mid-bit.
REQ-025 A tick coincident with the IDLE->START transition SHALL NOT be counted.
REQ-026 rx changes while busy SHALL NOT affect anything except through the mid-bit samples defined above.

Reset
REQ-027 With reset = 1 at a rising clk, SHALL set state = IDLE, cnt = 0, idx = 0, shift register = 0, synchronizer flops = 1, rx_data = 0, rx_valid = 0, rx_frame_err = 0, rx_parity_err = 0, busy = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no rx_valid pulse; reception SHALL resume only with a new falling edge after reset is released.

Verification
REQ-029 Defaults, tick every 4 clk, send 0xA5 with a good stop bit -> exactly one rx_valid pulse, rx_data = 0xA5, rx_frame_err = 0, busy = 0 afterwards.
REQ-030 rx low for 3 ticks, then high -> returns to IDLE; no rx_valid; a following 0x3C frame is received correctly.
REQ-031 Send 0x00 with the stop bit low, line held low 40 ticks, then high -> one rx_valid, rx_data = 0x00, rx_frame_err = 1; FSM in BREAK until the line is high, then 0xFF is received with rx_frame_err = 0.
REQ-032 PARITY_EN = 1, PARITY_ODD = 0: send 0x07 with parity bit 1 -> rx_parity_err = 0; send 0x07 with parity bit 0 -> rx_parity_err = 1.
REQ-033 Assert reset for 1 clk during data bit 4 of a frame -> all outputs 0, no rx_valid; the next full 0x5A frame -> rx_data = 0x5A.
REQ-034 Back-to-back frames 0x11 and 0x22 with a single stop bit and no idle gap -> two rx_valid pulses, rx_data values in order.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 16x oversampling UART receiver with optional parity
//
// Receives asynchronous serial frames (start, DATA_BITS payload LSB first,
// optional parity, one stop bit) using a 16x-baud tick enable. Bits are sampled
// at mid-bit. A stop bit sampled low reports a framing error, and the receiver
// waits in BREAK until the line returns high.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   tick          in   16x-baud enable, one clk wide
//   rx            in   asynchronous serial line, idles high
//   rx_data       out  last received payload
//   rx_valid      out  one-clk pulse when rx_data / error flags update
//   rx_frame_err  out  stop bit of the last frame sampled low
//   rx_parity_err out  parity mismatch on the last frame (0 without parity)
//   busy          out  receiver is not idle

module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);
  localparam logic       ODD_BIT  = (PARITY_ODD != 0);
  localparam logic       PAR_USED = (PARITY_EN != 0);

  state_t               state, state_n;
  logic                 rx_meta, rx_s;
  logic [3:0]           cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_err, par_err_n;
  logic                 load;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shreg_n   = shreg;
    par_err_n = par_err;
    load      = 1'b0;

    case (state)
      IDLE: begin
        // A tick arriving together with the start detection is not counted.
        cnt_n = 4'd0;
        if (!rx_s) begin
          state_n = START;
        end
      end

      START: begin
        if (tick) begin
          if (cnt == 4'd7) begin
            cnt_n = 4'd0;
            idx_n = 3'd0;
            // Line back high at mid start bit: treat as a glitch.
            state_n = rx_s ? IDLE : DATA;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (cnt == 4'd15) begin
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            cnt_n   = 4'd0;
            idx_n   = idx + 3'd1;
            if (idx == LAST_IDX) begin
              state_n = PAR_USED ? PARITY : STOP;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          if (cnt == 4'd15) begin
            // Error when the XOR of payload and parity bit differs from the
            // selected sense (0 = even, 1 = odd).
            par_err_n = (^shreg) ^ rx_s ^ ODD_BIT;
            cnt_n     = 4'd0;
            state_n   = STOP;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (cnt == 4'd15) begin
            load    = 1'b1;
            cnt_n   = 4'd0;
            state_n = rx_s ? IDLE : BREAK;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end

      BREAK: begin
        // Held line-low condition; no start detection until the line is high.
        cnt_n = 4'd0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      cnt           <= 4'd0;
      idx           <= 3'd0;
      shreg         <= '0;
      par_err       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      par_err  <= par_err_n;
      rx_valid <= load;
      if (load) begin
        rx_data       <= shreg;
        rx_frame_err  <= ~rx_s;
        rx_parity_err <= PAR_USED & par_err;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
